// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, count-width helper and handshake status encoding for param_fifo
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 8;

    // Occupancy must represent 0..DEPTH inclusive, hence one bit more than the pointer.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_ACK  = 2'd1,
        HS_ERR  = 2'd2
    } hs_status_t;

endpackage

// File: rtl/param_fifo_if.sv
// rtl/param_fifo_if.sv - producer/consumer handshake bundle for param_fifo
// master: drives wr_en, d_in, rd_en; slave: drives d_out, full, empty, acks/errs, data_count.
interface param_fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) ();
    localparam int CNT_W = cnt_width(DEPTH);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] d_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  full;
    logic                  empty;
    logic                  wr_ack;
    logic                  wr_err;
    logic                  rd_ack;
    logic                  rd_err;
    logic [CNT_W-1:0]      data_count;

    modport master (
        output wr_en, d_in, rd_en,
        input  d_out, full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count
    );

    modport slave (
        input  wr_en, d_in, rd_en,
        output d_out, full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count
    );

endinterface

// File: rtl/param_read_mux.sv
// rtl/param_read_mux.sv - gated DEPTH-to-1 word selector over the FIFO register file
// words: flattened entries (entry i at bits i*DATA_WIDTH); sel: entry index; en: gate; word: selected entry or 0.
module param_read_mux
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic [DEPTH*DATA_WIDTH-1:0] words,
    input  logic [PTR_W-1:0]            sel,
    input  logic                        en,
    output logic [DATA_WIDTH-1:0]       word
);

    always_comb begin
        word = '0;
        if (en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sel == PTR_W'(i)) begin
                    word = words[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised synchronous FIFO with registered gated read port and per-cycle ack/err flags
// clk/rst: clock and synchronous active-high reset; bus: param_fifo_if slave (requests in, data/status out).
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    param_fifo_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH*DATA_WIDTH-1:0] mem_flat;
    logic [PTR_W-1:0]            head;
    logic [PTR_W-1:0]            tail;
    logic [CNT_W-1:0]            count;
    logic                        full;
    logic                        empty;
    logic                        wr_ok;
    logic                        rd_ok;
    logic [DATA_WIDTH-1:0]       rd_word;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO still takes a write when a read frees the head slot in the same edge.
    assign wr_ok = bus.wr_en && (!full || bus.rd_en);
    assign rd_ok = bus.rd_en && !empty;

    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.data_count = count;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign mem_flat[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
    end

    param_read_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_read_mux (
        .words (mem_flat),
        .sel   (head),
        .en    (rd_ok),
        .word  (rd_word)
    );

    // Storage is not reset; on full read+write head==tail and the mux sees the old word.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[tail] <= bus.d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            bus.d_out  <= '0;
            bus.wr_ack <= 1'b0;
            bus.wr_err <= 1'b0;
            bus.rd_ack <= 1'b0;
            bus.rd_err <= 1'b0;
        end else begin
            if (wr_ok) begin
                tail <= tail + 1'b1;
            end
            if (rd_ok) begin
                head <= head + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            bus.d_out  <= rd_word;
            bus.wr_ack <= wr_ok;
            bus.wr_err <= bus.wr_en && !wr_ok;
            bus.rd_ack <= rd_ok;
            bus.rd_err <= bus.rd_en && !rd_ok;
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - self-checking bench for param_fifo against a queue-based reference model
module tb_param_fifo;

    localparam int DW  = 32;
    localparam int DEP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    param_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEP)) bus ();

    param_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock: apply request, predict from the queue model, compare after the edge.
    task automatic step(input logic r, input logic w, input logic [DW-1:0] d,
                        input logic rd, input string tag);
        logic          w_acc;
        logic          r_acc;
        logic [DW-1:0] e_dout;
        rst       = r;
        bus.wr_en = w;
        bus.d_in  = d;
        bus.rd_en = rd;
        if (r) begin
            q.delete();
            w_acc  = 1'b0;
            r_acc  = 1'b0;
            e_dout = '0;
        end else begin
            w_acc  = w && (q.size() < DEP || rd);
            r_acc  = rd && (q.size() > 0);
            e_dout = r_acc ? q[0] : '0;
            if (r_acc) void'(q.pop_front());
            if (w_acc) q.push_back(d);
        end
        @(posedge clk);
        #1;
        check({tag, ".count"},  64'(bus.data_count), 64'(q.size()));
        check({tag, ".full"},   64'(bus.full),       64'(q.size() == DEP));
        check({tag, ".empty"},  64'(bus.empty),      64'(q.size() == 0));
        check({tag, ".d_out"},  64'(bus.d_out),      64'(e_dout));
        check({tag, ".wr_ack"}, 64'(bus.wr_ack),     64'(!r && w_acc));
        check({tag, ".wr_err"}, 64'(bus.wr_err),     64'(!r && w && !w_acc));
        check({tag, ".rd_ack"}, 64'(bus.rd_ack),     64'(!r && r_acc));
        check({tag, ".rd_err"}, 64'(bus.rd_err),     64'(!r && rd && !r_acc));
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.d_in  = '0;
        bus.rd_en = 1'b0;

        step(1, 0, 0, 0, "reset");
        step(0, 0, 0, 1, "rd_empty");
        step(0, 0, 0, 0, "idle");

        for (int i = 1; i <= 8; i++) step(0, 1, DW'(i * 'h11), 0, "fill");
        step(0, 1, 'h99, 0, "wr_full");
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, "drain");
        step(0, 0, 0, 0, "after_drain");

        for (int i = 0; i < 5; i++) step(0, 1, DW'('h100 + i), 0, "wrap_w5");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, "wrap_r5");
        for (int i = 0; i < 6; i++) step(0, 1, DW'('h200 + i), 0, "wrap_w6");
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, "wrap_r6");

        for (int i = 1; i <= 8; i++) step(0, 1, DW'(i * 'h11), 0, "refill");
        step(0, 1, 'hAA, 1, "rw_full");
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, "drain_aa");

        step(0, 1, 'h5A, 1, "rw_empty");
        step(0, 0, 0, 1, "rd_5a");

        for (int i = 0; i < 4; i++) step(0, 1, DW'('h300 + i), 0, "pre_rst");
        step(1, 1, 'h3FF, 0, "mid_rst");
        step(0, 0, 0, 1, "rd_after_rst");

        for (int i = 0; i < 3000; i++) begin
            int wp;
            int rp;
            wp = ((i / 200) % 2 == 0) ? 70 : 30;
            rp = 100 - wp;
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < wp,
                 DW'($urandom),
                 $urandom_range(0, 99) < rp,
                 "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
- Parametrised synchronous FIFO; successor to the fixed 8-entry, 32-bit FIFO.
- Width and depth are generalised. Adds simultaneous read/write, a registered gated read port, and per-cycle ack/error handshake flags.
- Sits between producer and consumer blocks in the datapath. Entry storage is a register file read through a parametrised N-to-1 read mux.

Parameters:
- DATA_WIDTH, 32, width of each entry and of d_in/d_out.
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width; derived.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous active-high reset, sampled on rising clk.
- wr_en  input  1  write request this cycle.
- d_in  input  DATA_WIDTH  write data, sampled with wr_en.
- rd_en  input  1  read request this cycle.
- d_out  output  DATA_WIDTH  registered read data.
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.
- wr_ack  output  1  registered; previous-cycle write accepted.
- wr_err  output  1  registered; previous-cycle write rejected.
- rd_ack  output  1  registered; previous-cycle read accepted.
- rd_err  output  1  registered; previous-cycle read rejected.
- data_count  output  CNT_W  current occupancy.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge): head=0, tail=0, data_count=0, d_out=0, all ack/err=0. Flags then read empty=1, full=0.
- rst has priority over wr_en/rd_en in the same cycle. Entry contents are not cleared.
- Reset mid-operation discards all stored data. The first read after reset therefore reports rd_err.
- full and empty are combinational from data_count, so they are valid in the same cycle the count changes.
- Write acceptance: wr_en=1 and (full=0, or full=1 with rd_en=1).
  - On acceptance: mem[tail] <= d_in; tail <= tail+1, wrapping mod DEPTH by natural PTR_W overflow.
- Read acceptance: rd_en=1 and empty=0.
  - On acceptance: d_out <= mem[head] via the read mux; head <= head+1, wrapping.
- Read latency: d_out shows the popped word one cycle after the accepting edge.
- d_out when no read is accepted: d_out <= 0 (gated output, same convention as the mux enable).
- data_count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- Simultaneous rd_en and wr_en:
  - Empty: write accepted, read rejected (rd_err=1). No bypass; data becomes readable next cycle.
  - Full: both accepted. The oldest word is output, the new word is stored in the freed slot, and the count stays at DEPTH.
  - Otherwise: both accepted.
- Handshake flags are registered, asserted for exactly one cycle per request, and reflect the request of the previous edge.
  - wr_err=1: wr_en=1 rejected while full with no read.
  - rd_err=1: rd_en=1 rejected while empty.
  - No request: ack/err=0.
  - wr_ack/wr_err are mutually exclusive, and so are rd_ack/rd_err.
- Rejected operations change no pointer, count or memory.

Decomposition:
- Shared package fifo_pkg holds:
  - default width/depth constants;
  - a function computing the count width;
  - the handshake status encoding, if status is exported later.
- One sub-module, param_read_mux: DEPTH-to-1 mux of DATA_WIDTH words, with a sel input of PTR_W bits and an enable.
  - Output is 0 when enable=0.
  - Enable is driven by read acceptance.

Test Plan:
- Reset then rd_en=1 for 1 cycle -> next cycle rd_err=1, rd_ack=0, d_out=0, empty=1, data_count=0.
- Write 0x11..0x88 (8 words, DEPTH=8) -> full=1 after 8th edge, data_count=8. A 9th write 0x99 -> wr_err=1, and the count stays 8.
- Read 8 times after the fill -> d_out=0x11,0x22,...,0x88 on successive cycles, rd_ack=1 each, empty=1 at end. d_out=0 the cycle after the last read.
- Pointer wrap: write 5, read 5, write 6, read 6 -> read order matches write order across the index 7->0 wrap; data_count returns to 0.
- Simultaneous rd/wr on full (contents 0x11..0x88, d_in=0xAA) -> d_out=0x11, wr_ack=rd_ack=1, data_count=8. The 8th subsequent read returns 0xAA.
- Simultaneous rd/wr on empty (d_in=0x5A) -> wr_ack=1, rd_err=1, data_count=1, d_out=0. The next read returns 0x5A.
- Assert rst mid-stream with data_count=4 and wr_en=1 -> next cycle data_count=0, wr_ack=0, empty=1.
